// File: rtl/biriscv_csr_wb_pipe_pkg.sv
// Types shared by the CSR E2/WB pipeline stages.
package biriscv_csr_wb_pipe_pkg;
    import biriscv_defs::*;

    // In WB, value carries the merged exception address rather than the CSR read value.
    typedef struct packed {
        logic                   csr_write;
        logic [31:0]            opcode;
        logic [31:0]            pc;
        logic [31:0]            wdata;
        logic [31:0]            value;
        logic [EXCEPTION_W-1:0] exception;
    } csr_stage_t;

    function automatic logic [11:0] csr_addr(input logic [31:0] opcode);
        return opcode[31:20];
    endfunction

endpackage

// File: rtl/biriscv_defs.sv
// Shared biriscv core definitions: exception width and exception cause codes.
package biriscv_defs;

    localparam int EXCEPTION_W = 6;

    localparam logic [EXCEPTION_W-1:0] EXCEPTION_NONE                = 6'h00;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_ILLEGAL_INSTRUCTION = 6'h02;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_LOAD          = 6'h05;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_STORE         = 6'h07;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_ECALL               = 6'h0b;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_ERET                = 6'h30;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FENCE               = 6'h31;

endpackage

// File: rtl/biriscv_csr_wb_pipe_if.sv
// E1 request, LSU fault and CSR writeback signals of the CSR E2/WB pipeline.
interface biriscv_csr_wb_pipe_if;
    import biriscv_defs::*;

    logic                   e1_valid_i;
    logic [31:0]            e1_opcode_i;
    logic [31:0]            e1_pc_i;
    logic                   e1_csr_write_i;
    logic [31:0]            e1_csr_wdata_i;
    logic [31:0]            e1_csr_value_i;
    logic [EXCEPTION_W-1:0] e1_exception_i;
    logic [EXCEPTION_W-1:0] mem_exception_e2_i;
    logic [31:0]            mem_fault_addr_e2_i;
    logic                   stall_i;
    logic                   squash_i;

    logic                   csr_writeback_write_o;
    logic [11:0]            csr_writeback_waddr_o;
    logic [31:0]            csr_writeback_wdata_o;
    logic [EXCEPTION_W-1:0] csr_writeback_exception_o;
    logic [31:0]            csr_writeback_exception_pc_o;
    logic [31:0]            csr_writeback_exception_addr_o;

    modport master (
        output e1_valid_i, e1_opcode_i, e1_pc_i, e1_csr_write_i, e1_csr_wdata_i,
               e1_csr_value_i, e1_exception_i, mem_exception_e2_i, mem_fault_addr_e2_i,
               stall_i, squash_i,
        input  csr_writeback_write_o, csr_writeback_waddr_o, csr_writeback_wdata_o,
               csr_writeback_exception_o, csr_writeback_exception_pc_o,
               csr_writeback_exception_addr_o
    );

    modport slave (
        input  e1_valid_i, e1_opcode_i, e1_pc_i, e1_csr_write_i, e1_csr_wdata_i,
               e1_csr_value_i, e1_exception_i, mem_exception_e2_i, mem_fault_addr_e2_i,
               stall_i, squash_i,
        output csr_writeback_write_o, csr_writeback_waddr_o, csr_writeback_wdata_o,
               csr_writeback_exception_o, csr_writeback_exception_pc_o,
               csr_writeback_exception_addr_o
    );

endinterface

// File: rtl/biriscv_csr_wb_stage.sv
// One CSR pipeline stage register with valid, hold on stall and kill.
module biriscv_csr_wb_stage
    import biriscv_csr_wb_pipe_pkg::*;
#(
    // When clear, a stalled stage drops its valid so the next stage never repeats a pulse.
    parameter bit HoldValid = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       advance_i,
    input  logic       kill_i,
    input  logic       valid_i,
    input  csr_stage_t data_i,
    output logic       valid_o,
    output csr_stage_t data_o
);

    logic       valid_q, valid_d;
    csr_stage_t data_q, data_d;

    always_comb begin
        valid_d = advance_i ? valid_i : (HoldValid ? valid_q : 1'b0);
        if (kill_i) begin
            valid_d = 1'b0;
        end
        data_d = advance_i ? data_i : data_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/biriscv_csr_wb_pipe.sv
// CSR E2/WB pipeline: merges E1 and LSU exceptions and issues one writeback pulse per instruction.
module biriscv_csr_wb_pipe
    import biriscv_defs::*;
    import biriscv_csr_wb_pipe_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    biriscv_csr_wb_pipe_if.slave bus
);

    logic       advance;
    logic       kill;
    logic       e2_valid;
    logic       wb_valid;
    csr_stage_t e1_data;
    csr_stage_t e2_data;
    csr_stage_t wb_in;
    csr_stage_t wb_data;

    assign advance = !bus.stall_i;
    // A faulting instruction leaving WB flushes everything younger in the same cycle.
    assign kill    = bus.squash_i || (wb_valid && (wb_data.exception != EXCEPTION_NONE));

    always_comb begin
        e1_data.csr_write = bus.e1_csr_write_i;
        e1_data.opcode    = bus.e1_opcode_i;
        e1_data.pc        = bus.e1_pc_i;
        e1_data.wdata     = bus.e1_csr_wdata_i;
        e1_data.value     = bus.e1_csr_value_i;
        e1_data.exception = bus.e1_exception_i;
    end

    // E1 exceptions take priority over the LSU fault; value becomes the exception address.
    always_comb begin
        wb_in = e2_data;
        if (e2_data.exception != EXCEPTION_NONE) begin
            wb_in.value = e2_data.value;
        end else if (bus.mem_exception_e2_i != EXCEPTION_NONE) begin
            wb_in.exception = bus.mem_exception_e2_i;
            wb_in.value     = bus.mem_fault_addr_e2_i;
        end else begin
            wb_in.value = '0;
        end
    end

    biriscv_csr_wb_stage #(
        .HoldValid(1'b1)
    ) u_e2 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .advance_i(advance),
        .kill_i   (kill),
        .valid_i  (bus.e1_valid_i),
        .data_i   (e1_data),
        .valid_o  (e2_valid),
        .data_o   (e2_data)
    );

    biriscv_csr_wb_stage #(
        .HoldValid(1'b0)
    ) u_wb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .advance_i(advance),
        .kill_i   (kill),
        .valid_i  (e2_valid),
        .data_i   (wb_in),
        .valid_o  (wb_valid),
        .data_o   (wb_data)
    );

    always_comb begin
        bus.csr_writeback_write_o          = wb_valid && wb_data.csr_write &&
                                             (wb_data.exception == EXCEPTION_NONE);
        bus.csr_writeback_waddr_o          = wb_valid ? csr_addr(wb_data.opcode) : 12'h000;
        bus.csr_writeback_wdata_o          = wb_valid ? wb_data.wdata : 32'h0;
        bus.csr_writeback_exception_o      = wb_valid ? wb_data.exception : EXCEPTION_NONE;
        bus.csr_writeback_exception_pc_o   = wb_valid ? wb_data.pc : 32'h0;
        bus.csr_writeback_exception_addr_o = wb_valid ? wb_data.value : 32'h0;
    end

    logic unused_opcode_low;
    assign unused_opcode_low = ^wb_data.opcode[19:0];

endmodule

// File: doc/biriscv_csr_wb_pipe.md
BIRISCV_CSR_WB_PIPE -- requirements
Module: biriscv_csr_wb_pipe

Interface
REQ-001 The block SHALL have clk_i, input, 1 bit: the single clock.
REQ-002 The block SHALL have rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have e1_valid_i, input, 1 bit: an instruction occupies the CSR E1 slot.
REQ-004 The block SHALL have e1_opcode_i, input, 32 bits: E1 opcode; bits [31:20] give the CSR address.
REQ-005 The block SHALL have e1_pc_i, input, 32 bits: E1 instruction PC.
REQ-006 The block SHALL have e1_csr_write_i, input, 1 bit: the E1 CSR write request.
REQ-007 The block SHALL have e1_csr_wdata_i, input, 32 bits: the E1 CSR write data.
REQ-008 The block SHALL have e1_csr_value_i, input, 32 bits: the E1 CSR read value, or the faulting opcode on an illegal instruction.
REQ-009 The block SHALL have e1_exception_i, input, 6 bits: the E1 exception code; 0 means none.
REQ-010 The block SHALL have mem_exception_e2_i, input, 6 bits, and mem_fault_addr_e2_i, input, 32 bits: the LSU fault for the instruction in E2.
REQ-011 The block SHALL have stall_i, input, 1 bit: hold the pipeline.
REQ-012 The block SHALL have squash_i, input, 1 bit: external flush of everything younger than WB.
REQ-013 The block SHALL have csr_writeback_write_o, output, 1 bit.
REQ-014 The block SHALL have csr_writeback_waddr_o, output, 12 bits.
REQ-015 The block SHALL have csr_writeback_wdata_o, output, 32 bits.
REQ-016 The block SHALL have csr_writeback_exception_o, output, 6 bits.
REQ-017 The block SHALL have csr_writeback_exception_pc_o, output, 32 bits.
REQ-018 The block SHALL have csr_writeback_exception_addr_o, output, 32 bits.

Function
REQ-019 The block SHALL implement two register stages, E2 and WB, each with a valid flag.
- advance = !stall_i.
REQ-020 On advance, E2 SHALL load e1_valid_i && !kill, where kill = squash_i || (wb_valid && wb_exception != 0).
REQ-021 While stalled, E2 SHALL hold its contents, except that kill SHALL clear E2 valid regardless of stall.
REQ-022 On advance, WB valid SHALL become E2 valid && !kill; while stalled, WB valid SHALL become 0.
- Result: each instruction produces exactly one WB pulse, and nothing is ever repeated.
REQ-023 Exception merge at the E2→WB transfer SHALL be:
- wb_exception = e2 E1 exception if it is nonzero;
- otherwise mem_exception_e2_i;
- otherwise 0.
REQ-024 exception_addr SHALL be:
- e2 csr_value when the selected code came from E1 (e.g. illegal instruction, 0x02, gives the opcode);
- mem_fault_addr_e2_i when the code came from the LSU;
- 0 when there is no exception.
REQ-025 csr_writeback_write_o SHALL be wb_valid && wb_csr_write && wb_exception == 0.
REQ-026 waddr, wdata, exception, exception_pc and exception_addr outputs SHALL drive 0 whenever wb_valid is 0.
REQ-027 Latency SHALL be 2 cycles with no stall: E1 sampled at edge N appears on the outputs after edge N+1.
- Each stall cycle adds one cycle.
REQ-028 Simultaneous squash_i and stall_i SHALL clear both E2 and the WB pulse.
REQ-029 An exception leaving WB SHALL kill the E2 occupant at the same edge, and younger E1 instructions SHALL also be discarded that cycle.
REQ-030 waddr SHALL equal opcode[31:20] of the WB instruction; wdata SHALL pass through unmodified, with no width extension.

Reset
REQ-031 Reset SHALL be asynchronous on posedge rst_i.
REQ-032 Reset SHALL clear both valid flags and all stage data to 0.
REQ-033 Every output SHALL be 0 while rst_i is high.
REQ-034 Reset asserted mid-operation SHALL discard in-flight instructions with no writeback pulse.

Structure
REQ-035 EXCEPTION_W and the exception code constants (ILLEGAL_INSTRUCTION 0x02, FAULT_LOAD 0x05, FAULT_STORE 0x07, ECALL, ERET, FENCE) SHALL come from the shared biriscv_defs definitions, not local literals.
REQ-036 A single sub-module, biriscv_csr_wb_stage, holding one stage register set with valid/hold/kill, SHALL be instantiated twice for E2 and WB.

Verification
REQ-037 CSRRW mscratch: e1_valid=1, opcode[31:20]=0x340, write=1, wdata=0xDEADBEEF, no stall -> write=1, waddr=0x340, wdata=0xDEADBEEF, two cycles later for exactly 1 cycle.
REQ-038 Illegal instruction: e1_exception=0x02, value=0x00000073, pc=0x80000010 -> exception=0x02, exception_pc=0x80000010, addr=0x00000073, write=0.
REQ-039 LSU fault: e1_exception=0, mem_exception_e2=0x05, fault_addr=0x1000 -> exception=0x05, addr=0x1000; the following E1 instruction produces no pulse.
REQ-040 Stall: stall_i high for 3 cycles with an instruction in E2 -> one pulse only, 3 cycles late, with waddr/wdata unchanged.
REQ-041 Squash: squash_i pulsed while E2 is valid -> no writeback output for that instruction.
REQ-042 Reset mid-flight: rst_i asserted with E2 and WB valid -> all outputs 0 immediately, and no pulse after release.
